// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with one-shot and auto-reload modes.
// Registers: CTRL (enable/mode/IM), PRESET, COUNT (read-only).
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timerState;
    timerState   state, stateNext;
    logic        enable, im, irqPending;
    logic [1:0]  mode;
    logic [31:0] preset, count, countNext;
    logic        pendingSet, pendingClr, enableClr;
    logic        ctrlWr, presetWr;
    assign ctrlWr   = we && addr == 2'd0;
    assign presetWr = we && addr == 2'd1;
    assign irq      = im & irqPending;
    assign rdata    = addr == 2'd0 ? {28'd0, im, mode, enable} :
                      addr == 2'd1 ? preset :
                      addr == 2'd2 ? count : 32'd0;
    always_comb begin
        stateNext  = state;
        countNext  = count;
        pendingSet = 1'b0;
        pendingClr = 1'b0;
        enableClr  = 1'b0;
        case (state)
            IDLE: stateNext = enable ? LOAD : IDLE;
            LOAD: begin
                countNext = preset;
                stateNext = CNT;
            end
            CNT: begin
                if (!enable) stateNext = IDLE;
                else if (count > 32'd1) countNext = count - 32'd1;
                else begin
                    countNext  = 32'd0;
                    stateNext  = INT;
                    pendingSet = 1'b1;
                end
            end
            INT: begin
                // Only mode 1 reloads; modes 0, 2 and 3 are one-shot.
                stateNext  = mode == 2'd1 ? LOAD : IDLE;
                pendingClr = mode == 2'd1;
                enableClr  = mode != 2'd1;
            end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            enable     <= 1'b0;
            mode       <= 2'd0;
            im         <= 1'b0;
            preset     <= 32'd0;
            count      <= 32'd0;
            irqPending <= 1'b0;
        end else begin
            count <= countNext;
            // A bus write to CTRL takes priority over the FSM's enable clear.
            if (ctrlWr) {im, mode, enable} <= wdata[3:0];
            else if (enableClr) enable <= 1'b0;
            if (presetWr) preset <= wdata;
            irqPending <= ctrlWr ? 1'b0 : pendingSet ? 1'b1 : pendingClr ? 1'b0 : irqPending;
        end
    end
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed checks of timer_device register access, counting and irq timing.
module tb_timer_device;
    logic        clk, reset, we, irq;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    int total = 0;
    int bad = 0;

    timer_device dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chkIrq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        tick;
        tick;
        reset = 1'b0;
        rd(0, "rst_ctrl", 0);
        rd(1, "rst_preset", 0);
        rd(2, "rst_count", 0);
        rd(3, "rst_rsvd", 0);
        chkIrq("rst_irq", 1'b0);

        // One-shot, PRESET=3, IM=1
        wr(1, 3);
        wr(0, 32'h9);
        tick;
        tick;
        rd(2, "os_cnt_e2", 3);
        tick;
        rd(2, "os_cnt_e3", 2);
        tick;
        rd(2, "os_cnt_e4", 1);
        chkIrq("os_irq_e4", 1'b0);
        tick;
        rd(2, "os_cnt_e5", 0);
        chkIrq("os_irq_e5", 1'b1);
        tick;
        chkIrq("os_irq_e6", 1'b1);
        rd(0, "os_ctrl_e6", 32'h8);

        wr(0, 32'h0);
        chkIrq("clr_irq", 1'b0);
        tick;
        tick;
        rd(2, "clr_cnt", 0);
        chkIrq("clr_irq_hold", 1'b0);

        // Auto-reload, PRESET=3: INT every 5 cycles
        wr(0, 32'hB);
        for (int i = 1; i <= 15; i++) begin
            tick;
            chkIrq($sformatf("ar_irq_e%0d", i), (i == 5 || i == 10 || i == 15));
        end
        rd(0, "ar_ctrl", 32'hB);
        wr(0, 32'h0);
        tick;
        tick;
        tick;

        // IM=0: pending set but masked, CTRL write clears it and wins over enable clear
        wr(1, 5);
        wr(0, 32'h1);
        for (int i = 1; i <= 7; i++) begin
            tick;
            chkIrq($sformatf("im0_irq_e%0d", i), 1'b0);
        end
        rd(2, "im0_cnt_e7", 0);
        rd(0, "im0_ctrl_e7", 32'h1);
        wr(0, 32'h9);
        chkIrq("im0_irq_wr", 1'b0);
        rd(0, "im0_ctrl_wr", 32'h9);
        tick;
        chkIrq("im0_irq_e9", 1'b0);
        tick;
        rd(2, "im0_cnt_e10", 5);
        wr(0, 32'h0);
        tick;
        tick;

        // COUNT writes ignored, PRESET write deferred to next reload
        wr(1, 4);
        wr(0, 32'hB);
        tick;
        tick;
        rd(2, "mid_cnt_e2", 4);
        wr(2, 32'hFFFF);
        rd(2, "mid_cnt_e3", 3);
        wr(1, 7);
        rd(2, "mid_cnt_e4", 2);
        tick;
        rd(2, "mid_cnt_e5", 1);
        tick;
        rd(2, "mid_cnt_e6", 0);
        chkIrq("mid_irq_e6", 1'b1);
        tick;
        chkIrq("mid_irq_e7", 1'b0);
        tick;
        rd(2, "mid_cnt_e8", 7);
        wr(0, 32'h0);
        rd(2, "mid_cnt_e9", 6);
        tick;
        tick;
        rd(2, "mid_cnt_frozen", 6);
        wr(3, 32'hDEAD);
        rd(3, "rsvd_rd", 0);
        rd(1, "preset_rd", 7);

        // PRESET=0 behaves as 1
        wr(1, 0);
        wr(0, 32'h9);
        tick;
        tick;
        rd(2, "p0_cnt_e2", 0);
        chkIrq("p0_irq_e2", 1'b0);
        tick;
        chkIrq("p0_irq_e3", 1'b1);
        wr(0, 32'h0);
        tick;

        // Reset mid-count
        wr(1, 3);
        wr(0, 32'h9);
        tick;
        tick;
        tick;
        rd(2, "rr_cnt_e3", 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        rd(0, "rr_ctrl", 0);
        rd(1, "rr_preset", 0);
        rd(2, "rr_count", 0);
        chkIrq("rr_irq", 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick;
            chkIrq($sformatf("rr_irq_c%0d", i), 1'b0);
            rd(2, $sformatf("rr_cnt_c%0d", i), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
